vga_vram_arbiter: RTL

Shares a single-port video RAM between the VGA scan-out fetch and two write requesters (drawing engine, host). It runs in the 25.175 MHz pixel clock domain and is driven by the pixel cursor's hcount/vcount. Display fetches own fixed time slots. The remaining cycles go to the writers by round-robin. It also unpacks fetched words into a registered pixel stream for the DAC stage.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/vga_vram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Display timing, VRAM geometry and the pixel-to-word address helper shared
// by the VGA video RAM arbiter and its sub-blocks.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam int unsigned WORD_PIX = 4;
  localparam int unsigned LANE_W   = $clog2(WORD_PIX);
  localparam int unsigned WPL      = 32'(H_ACTIVE) / WORD_PIX;
  localparam logic [31:0] VRAM_WORDS = WPL * 32'(V_ACTIVE);

  // Last in-line prefetch column and the column that prefetches the next line's word 0.
  localparam logic [9:0] H_FETCH_LAST = H_ACTIVE - 10'(2 * WORD_PIX);
  localparam logic [9:0] H_HEAD_FETCH = H_TOTAL - 10'(WORD_PIX);

  function automatic logic [31:0] word_addr(input logic [9:0] y, input logic [9:0] x);
    return 32'(y) * WPL + 32'(x) / WORD_PIX;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; when both requesters are valid the one that
// did not win the previous accepted transfer is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_lastGrant;

  always_comb begin
    o_grant = 2'b00;
    if (i_accept) begin
      if (i_req[1] && (!i_req[0] || !r_lastGrant)) begin
        o_grant = 2'b10;
      end else if (i_req[0]) begin
        o_grant = 2'b01;
      end
    end
  end

  // Any grant is a completed transfer because grant implies valid & ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lastGrant <= 1'b1;
    end else if (|o_grant) begin
      r_lastGrant <= o_grant[1];
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between scan-out fetches and two writers, and
// unpacks fetched words into a registered pixel stream. Optional macro:
// VRAM_ARB_TEAR_GUARD_EN restricts writes to the vertical blanking lines.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              err_oob
);

  logic [9:0]        w_nextLine;
  logic              w_lineFetch;
  logic              w_headFetch;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetchAddr;
  logic              w_writeSlot;
  logic [1:0]        w_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_winAddr;
  logic [DATA_W-1:0] w_winData;
  logic              w_winOob;
  logic              w_active;
  logic [LANE_W-1:0] w_lane;
  logic [DATA_W-1:0] w_word;

  logic              r_rdPend;
  logic [DATA_W-1:0] r_nextWord;
  logic [DATA_W-1:0] r_curWord;
  logic [PIX_W-1:0]  r_pix;
  logic              r_pixValid;
  logic              r_errOob;

  assign w_nextLine  = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
  assign w_lane      = hcount[LANE_W-1:0];

  assign w_lineFetch = reset_n && (w_lane == '0) && (hcount <= H_FETCH_LAST) &&
                       (vcount < V_ACTIVE);
  assign w_headFetch = reset_n && (hcount == H_HEAD_FETCH) && (w_nextLine < V_ACTIVE);
  assign w_fetch     = w_lineFetch | w_headFetch;

  // An in-line slot fetches the word one ahead of the cursor's current word.
  assign w_fetchAddr = w_headFetch ? ADDR_W'(word_addr(w_nextLine, 10'd0))
                                   : ADDR_W'(word_addr(vcount, hcount) + 32'd1);

`ifdef VRAM_ARB_TEAR_GUARD_EN
  assign w_writeSlot = reset_n & ~w_fetch & (vcount >= V_ACTIVE);
`else
  assign w_writeSlot = reset_n & ~w_fetch;
`endif

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    ({req1_valid, req0_valid}),
    .i_accept (w_writeSlot),
    .o_grant  (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_xfer     = |w_grant;
  assign w_winAddr  = w_grant[1] ? req1_addr  : req0_addr;
  assign w_winData  = w_grant[1] ? req1_wdata : req0_wdata;
  assign w_winOob   = 32'(w_winAddr) >= VRAM_WORDS;

  // Out-of-range writes finish the handshake but never reach the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_fetch) begin
      mem_en   = 1'b1;
      mem_addr = w_fetchAddr;
    end else if (w_xfer) begin
      mem_addr  = w_winAddr;
      mem_wdata = w_winData;
      if (!w_winOob) begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
    end
  end

  assign w_active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  // On the first column of a word the freshly landed word is used directly.
  assign w_word   = (w_lane == '0) ? r_nextWord : r_curWord;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdPend   <= 1'b0;
      r_nextWord <= '0;
      r_curWord  <= '0;
      r_pix      <= '0;
      r_pixValid <= 1'b0;
      r_errOob   <= 1'b0;
    end else begin
      r_rdPend <= w_fetch;
      if (r_rdPend) begin
        r_nextWord <= mem_rdata;
      end
      if (w_active && (w_lane == '0)) begin
        r_curWord <= r_nextWord;
      end
      r_pixValid <= w_active;
      r_pix      <= w_active ? w_word[w_lane * PIX_W +: PIX_W] : '0;
      if (w_xfer && w_winOob) begin
        r_errOob <= 1'b1;
      end
    end
  end

  assign pix_out   = r_pix;
  assign pix_valid = r_pixValid;
  assign err_oob   = r_errOob;

endmodule
